riscv_multicycle: RTL

RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

---
 rtl/riscv_multicycle.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle.sv
// -----------------------------------------------------------------------------
// riscv_multicycle
//
// Small multi-cycle RV32 core. Each instruction walks the state machine
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and then returns to FETCH.
// ebreak or any unsupported encoding parks the core in HALT until reset.
//
// Supported instructions: add, sub, and, or, slt, addi, andi, ori, slti,
//                         lw, sw, beq, bne.
//
// Instruction latency:
//   branch : 3 cycles (FETCH, DECODE, EXEC)
//   ALU    : 4 cycles (FETCH, DECODE, EXEC, WB)
//   sw     : 4 cycles (FETCH, DECODE, EXEC, MEM)
//   lw     : 5 cycles (FETCH, DECODE, EXEC, MEM, WB)
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         asynchronous, active-low reset
//   imem_we     instruction-memory write strobe (program load)
//   imem_addr   instruction-memory word index (program load)
//   imem_wdata  instruction word to write (program load)
//   pc          current program counter (byte address)
//   writedata   register-file write value while in WB, 0 otherwise
//   retire      high during the last cycle of each instruction
//   halted      high while the core sits in HALT
//   instret     number of retired instructions (wraps at 2^32)
//
// Memory behaviour:
//   imem and dmem are not touched by reset. dmem word i powers up holding i.
// -----------------------------------------------------------------------------
module riscv_multicycle #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   writedata,
    output logic                          retire,
    output logic                          halted,
    output logic [31:0]                   instret
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] a_q,       a_d;
    logic [31:0] b_q,       b_d;
    logic [31:0] imm_q,     imm_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q,     mdr_d;
    logic [31:0] instret_q, instret_d;

    logic [31:0] rf_q [32];
    logic [31:0] imem_mem [IMEM_DEPTH];
    logic [31:0] dmem_rd [DMEM_DEPTH];

    logic        rf_we;
    logic        dmem_we;
    logic [31:0] wb_value;

    // -------------------------------------------------------------------------
    // Instruction fields (IR holds the instruction from DECODE onwards)
    // -------------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // Anything outside the supported subset is treated like ebreak.
    logic legal;
    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            legal = ((funct7 == 7'b0000000) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000));
        end else if (is_i) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (is_load || is_store) begin
            legal = (funct3 == 3'b010);
        end else if (is_branch) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        end
    end

    // -------------------------------------------------------------------------
    // Immediate generation
    // -------------------------------------------------------------------------
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_sel;

    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_sel = is_store ? imm_s : (is_branch ? imm_b : imm_i);

    // -------------------------------------------------------------------------
    // Register-file read ports; x0 always reads as zero
    // -------------------------------------------------------------------------
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // -------------------------------------------------------------------------
    // ALU: R-type uses B, everything else uses the immediate.
    // Loads and stores fall through to the default add for address generation.
    // -------------------------------------------------------------------------
    logic [31:0] alu_b;
    logic [31:0] alu_res;

    assign alu_b = is_r ? b_q : imm_q;

    always_comb begin
        alu_res = a_q + alu_b;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_res = (is_r && funct7[5]) ? (a_q - alu_b) : (a_q + alu_b);
                3'b010:  alu_res = {31'd0, ($signed(a_q) < $signed(alu_b))};
                3'b110:  alu_res = a_q | alu_b;
                3'b111:  alu_res = a_q & alu_b;
                default: alu_res = a_q + alu_b;
            endcase
        end
    end

    // funct3[0] distinguishes bne from beq
    logic branch_taken;
    assign branch_taken = funct3[0] ? (a_q != b_q) : (a_q == b_q);

    logic [DMEM_AW-1:0] dmem_idx;
    assign dmem_idx = alu_out_q[DMEM_AW+1:2];

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;
        wb_value  = is_load ? mdr_q : alu_out_q;
        writedata = 32'd0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = imem_mem[pc_q[IMEM_AW+1:2]];
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                if ((ir_q == EBREAK) || !legal) begin
                    state_d = ST_HALT;
                end else begin
                    a_d     = rs1_val;
                    b_d     = rs2_val;
                    imm_d   = imm_sel;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (is_branch) begin
                    pc_d    = branch_taken ? (pc_q + imm_q) : (pc_q + 32'd4);
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    alu_out_d = alu_res;
                    state_d   = (is_load || is_store) ? ST_MEM : ST_WB;
                end
            end

            ST_MEM: begin
                if (is_load) begin
                    mdr_d   = dmem_rd[dmem_idx];
                    state_d = ST_WB;
                end else begin
                    dmem_we = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_WB: begin
                writedata = wb_value;
                rf_we     = (rd != 5'd0);
                pc_d      = pc_q + 32'd4;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Control / datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            imm_q     <= 32'd0;
            alu_out_q <= 32'd0;
            mdr_q     <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    // Register file: cleared by reset, x0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we) begin
            rf_q[rd] <= wb_value;
        end
    end

    // Instruction memory: the load port writes in any state; a FETCH of the
    // same word in the same cycle sees the previous contents.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_mem[imem_addr] <= imem_wdata;
        end
    end

    // Data memory: one register per word so each can carry its own power-up
    // value (word i holds i). Not reset; a store aborted by reset never
    // reaches here because dmem_we depends on the already-reset state.
    genvar gi;
    generate
        for (gi = 0; gi < DMEM_DEPTH; gi++) begin : g_dmem
            logic [31:0] word_q = 32'(gi);
            always_ff @(posedge clk) begin
                if (dmem_we && (dmem_idx == DMEM_AW'(gi))) begin
                    word_q <= b_q;
                end
            end
            assign dmem_rd[gi] = word_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc      = pc_q;
    assign instret = instret_q;
    assign halted  = (state_q == ST_HALT);

endmodule
